// File: rtl/perceptron_scheduler_if.sv
// Request, configuration and result bundle for the shared perceptron engine.
// The master side drives requests and weight writes; the slave side is the scheduler.
interface perceptron_scheduler_if #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned N     = 4
);
  localparam int unsigned AW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW  = $clog2(3 * WIDTH + 1);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       grant;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [1:0]         cfg_wdata;
  logic               busy;
  logic               res_valid;
  logic [1:0]         res_class;
  logic [IDW-1:0]     res_id;
  logic [SW-1:0]      res_sum;

  modport master (
    output req, req_data, cfg_we, cfg_addr, cfg_wdata,
    input  grant, busy, res_valid, res_class, res_id, res_sum
  );

  modport slave (
    input  req, req_data, cfg_we, cfg_addr, cfg_wdata,
    output grant, busy, res_valid, res_class, res_id, res_sum
  );
endinterface

// File: rtl/perceptron_scheduler.sv
// Round-robin arbitrated, bit-serial perceptron MAC shared among N requesters.
// One pattern bit is weighed per cycle; the sum is classified against two match values.
module perceptron_scheduler #(
  parameter int unsigned WIDTH   = 25,
  parameter int unsigned N       = 4,
  parameter int unsigned MATCH_A = 10,
  parameter int unsigned MATCH_B = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  perceptron_scheduler_if.slave sched_io
);
  localparam int unsigned AW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW  = $clog2(3 * WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StResult} state_e;

  state_e         state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [SW-1:0]  acc_q, acc_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [SW-1:0]  res_sum_q, res_sum_d;
  logic [1:0]     res_class_q, res_class_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [1:0]     weight_q [WIDTH];
  logic [1:0]     weight_d [WIDTH];

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           last_bit;
  int unsigned    cand;

  function automatic logic [1:0] default_weight(input int unsigned i);
    case (i)
      0, 4, 12, 20, 24: return 2'b10;
      2, 10, 14, 22:    return 2'b01;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [SW-1:0] s);
    if (s == SW'(MATCH_A))      return 2'b10;
    else if (s == SW'(MATCH_B)) return 2'b01;
    else                        return 2'b00;
  endfunction

  // First set request after the previous winner, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(last_q) + off) % N;
      if (!win_found && sched_io.req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  assign last_bit = (idx_q == AW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pattern_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      last_q      <= IDW'(N - 1);
      id_q        <= '0;
      res_sum_q   <= '0;
      res_class_q <= '0;
      res_id_q    <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        weight_q[i] <= default_weight(i);
      end
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      id_q        <= id_d;
      res_sum_q   <= res_sum_d;
      res_class_q <= res_class_d;
      res_id_q    <= res_id_d;
      weight_q    <= weight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (win_found) state_d = StRun;
      StRun:    if (last_bit) state_d = StResult;
      StResult: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    pattern_d   = pattern_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    last_d      = last_q;
    id_d        = id_q;
    res_sum_d   = res_sum_q;
    res_class_d = res_class_q;
    res_id_d    = res_id_q;
    weight_d    = weight_q;
    unique case (state_q)
      StIdle: begin
        // A write landing with a grant is visible to that job: RUN reads weights later.
        if (sched_io.cfg_we && (32'(sched_io.cfg_addr) < WIDTH)) begin
          weight_d[sched_io.cfg_addr] = sched_io.cfg_wdata;
        end
        if (win_found) begin
          pattern_d = sched_io.req_data[32'(win_idx) * WIDTH +: WIDTH];
          last_d    = win_idx;
          id_d      = win_idx;
          acc_d     = '0;
          idx_d     = '0;
        end
      end
      StRun: begin
        acc_d = acc_q + SW'(weight_q[idx_q] & {2{pattern_q[idx_q]}});
        idx_d = idx_q + AW'(1);
        if (last_bit) begin
          res_sum_d   = acc_d;
          res_class_d = classify(acc_d);
          res_id_d    = id_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sched_io.grant     = '0;
    sched_io.busy      = (state_q != StIdle);
    sched_io.res_valid = (state_q == StResult);
    if (state_q == StIdle && win_found) begin
      sched_io.grant = N'(1) << win_idx;
    end
  end

  assign sched_io.res_sum   = res_sum_q;
  assign sched_io.res_class = res_class_q;
  assign sched_io.res_id    = res_id_q;
endmodule

// File: tb/tb_perceptron_scheduler.sv
// Self-checking bench: directed scenarios plus random jobs against a transaction-level model
// holding the weight table and round-robin pointer.
module tb_perceptron_scheduler;
  localparam int unsigned WIDTH   = 25;
  localparam int unsigned N       = 4;
  localparam int unsigned MATCH_A = 10;
  localparam int unsigned MATCH_B = 4;
  localparam int unsigned AW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] PAT_A = 25'h1101011;
  localparam logic [WIDTH-1:0] PAT_B = 25'h0404404;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perceptron_scheduler_if #(.WIDTH(WIDTH), .N(N)) sched_if ();

  perceptron_scheduler #(
    .WIDTH  (WIDTH),
    .N      (N),
    .MATCH_A(MATCH_A),
    .MATCH_B(MATCH_B)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sched_io(sched_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cycle    = 0;
  int unsigned last_grant_cycle = 0;
  bit          have_last = 1'b0;
  int          mw [WIDTH];
  int          model_last;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < WIDTH; i++) begin
      if (i inside {0, 4, 12, 20, 24})  mw[i] = 2;
      else if (i inside {2, 10, 14, 22}) mw[i] = 1;
      else                              mw[i] = 0;
    end
    model_last = N - 1;
  endfunction

  function automatic int model_pick(input logic [N-1:0] rq);
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (model_last + off) % N;
      if (rq[k]) return k;
    end
    return -1;
  endfunction

  function automatic int model_sum(input logic [WIDTH-1:0] p);
    int s;
    s = 0;
    for (int i = 0; i < WIDTH; i++) if (p[i]) s += mw[i];
    return s;
  endfunction

  function automatic int model_class(input int s);
    if (s == MATCH_A) return 2;
    if (s == MATCH_B) return 1;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sched_if.req    = '0;
    sched_if.cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    have_last = 1'b0;
  endtask

  task automatic idle_write(input int addr, input int wd);
    sched_if.cfg_we    = 1'b1;
    sched_if.cfg_addr  = AW'(addr);
    sched_if.cfg_wdata = 2'(wd);
    @(posedge clk);
    #1;
    sched_if.cfg_we = 1'b0;
    if (addr < WIDTH) mw[addr] = wd;
  endtask

  // Called #1 after a rising edge with the scheduler idle; returns likewise.
  task automatic run_job(input logic [N-1:0] rq, input logic [N*WIDTH-1:0] data,
                         input bit pre_we, input int pre_addr, input int pre_wd,
                         input bit mid_we, input int mid_addr, input int mid_wd,
                         input logic [N-1:0] rq_after, input bit chk_gap);
    int w, s, lat;
    sched_if.req       = rq;
    sched_if.req_data  = data;
    sched_if.cfg_we    = pre_we;
    sched_if.cfg_addr  = AW'(pre_addr);
    sched_if.cfg_wdata = 2'(pre_wd);
    w = model_pick(rq);
    @(negedge clk);
    check_eq("grant", sched_if.grant, (w < 0) ? 0 : (1 << w));
    if (chk_gap && have_last) check_eq("grant_gap", cycle - last_grant_cycle, WIDTH + 2);
    last_grant_cycle = cycle;
    have_last = 1'b1;
    if (pre_we && pre_addr < WIDTH) mw[pre_addr] = pre_wd;
    @(posedge clk);
    #1;
    sched_if.req    = rq_after;
    sched_if.cfg_we = 1'b0;
    if (w < 0) return;
    s = model_sum(data[w*WIDTH +: WIDTH]);
    model_last = w;
    lat = 0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      if (mid_we && k == 3) begin
        sched_if.cfg_we    = 1'b1;
        sched_if.cfg_addr  = AW'(mid_addr);
        sched_if.cfg_wdata = 2'(mid_wd);
      end
      if (k == 4) sched_if.cfg_we = 1'b0;
      @(negedge clk);
      if (k == 1) check_eq("busy_run", sched_if.busy, 1);
      if (sched_if.res_valid) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("latency", lat, WIDTH + 1);
    check_eq("res_sum", sched_if.res_sum, s);
    check_eq("res_class", sched_if.res_class, model_class(s));
    check_eq("res_id", sched_if.res_id, w);
    check_eq("busy_result", sched_if.busy, 1);
    if (lat != 0) begin
      @(posedge clk);
      #1;
    end
    sched_if.cfg_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*WIDTH-1:0] d;
    int                 nvalid;
    sched_if.req       = '0;
    sched_if.req_data  = '0;
    sched_if.cfg_we    = 1'b0;
    sched_if.cfg_addr  = '0;
    sched_if.cfg_wdata = '0;
    do_reset();

    @(negedge clk);
    check_eq("rst_grant", sched_if.grant, 0);
    check_eq("rst_busy", sched_if.busy, 0);
    check_eq("rst_valid", sched_if.res_valid, 0);
    check_eq("rst_class", sched_if.res_class, 0);
    check_eq("rst_id", sched_if.res_id, 0);
    check_eq("rst_sum", sched_if.res_sum, 0);
    @(posedge clk);
    #1;

    d = '0;
    d[0 +: WIDTH] = PAT_A;
    run_job(4'b0001, d, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    d = '0;
    d[2*WIDTH +: WIDTH] = PAT_B;
    run_job(4'b0100, d, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    d[2*WIDTH +: WIDTH] = '1;
    run_job(4'b0100, d, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // All requesters held: rotation 0,1,2,3,0 at the back-to-back period.
    do_reset();
    for (int j = 0; j < N; j++) d[j*WIDTH +: WIDTH] = WIDTH'($urandom) | WIDTH'(1 << j);
    for (int j = 0; j < 5; j++) begin
      run_job(4'b1111, d, 0, 0, 0, 0, 0, 0, (j == 4) ? 4'b0000 : 4'b1111, 1);
    end

    idle_write(1, 3);
    d = '0;
    d[0 +: WIDTH] = 25'h2;
    run_job(4'b0001, d, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
    d[0 +: WIDTH] = 25'h1;
    run_job(4'b0001, d, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    idle_write(25, 3);
    d[0 +: WIDTH] = '1;
    run_job(4'b0001, d, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    d[0 +: WIDTH] = 25'h4;
    run_job(4'b0001, d, 1, 2, 3, 0, 0, 0, 4'b0000, 0);

    // Reset in the 10th RUN cycle discards the job.
    d = '0;
    d[0 +: WIDTH] = PAT_A;
    sched_if.req      = 4'b0001;
    sched_if.req_data = d;
    @(negedge clk);
    check_eq("mid_rst_grant", sched_if.grant, 1 << model_pick(4'b0001));
    @(posedge clk);
    #1;
    sched_if.req = '0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("mid_rst_busy", sched_if.busy, 0);
    check_eq("mid_rst_valid", sched_if.res_valid, 0);
    nvalid = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(negedge clk);
      if (sched_if.res_valid) nvalid++;
    end
    check_eq("mid_rst_no_valid", nvalid, 0);
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) d[j*WIDTH +: WIDTH] = PAT_A;
    run_job(4'b1111, d, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    for (int r = 0; r < 12; r++) begin
      logic [N-1:0] rq;
      if ($urandom_range(0, 1) == 1) idle_write($urandom_range(0, 31), $urandom_range(0, 3));
      rq = N'($urandom_range(1, (1 << N) - 1));
      for (int j = 0; j < N; j++) d[j*WIDTH +: WIDTH] = WIDTH'($urandom);
      run_job(rq, d, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1, $urandom_range(0, WIDTH - 1), $urandom_range(0, 3),
              4'b0000, 0);
    end

    @(negedge clk);
    check_eq("idle_no_grant", sched_if.grant, 0);
    check_eq("idle_busy", sched_if.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/perceptron_scheduler.md
Name: perceptron_scheduler

Overview:
- Shares one bit-serial perceptron MAC engine among N requesters. Each requester presents a WIDTH-bit binary pattern.
- A round-robin arbiter grants one requester and latches its pattern. The block walks the pattern one bit per cycle against a 2-bit weight RAM, accumulates the sum, then emits the 2-bit class tagged with the requester ID.
- The weight RAM is reconfigurable through a write port.
- The block sits between the input-pattern sources and downstream classification consumers.

Parameters:
- WIDTH, 25, pattern length in bits and number of weight entries.
- N, 4, number of requesters (N ≥ 1).
- MATCH_A, 10, sum value that yields class 2'b10.
- MATCH_B, 4, sum value that yields class 2'b01.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level.
- req_data  in  N*WIDTH  patterns; requester k occupies bits [k*WIDTH +: WIDTH].
- grant  out  N  one-hot, combinational; acceptance pulse.
- cfg_we  in  1  weight write enable.
- cfg_addr  in  AW=$clog2(WIDTH)  weight index.
- cfg_wdata  in  2  weight value.
- busy  out  1  high whenever the state is not IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_class  out  2  class of the last completed job.
- res_id  out  IDW=max(1,$clog2(N))  requester index of the last completed job.
- res_sum  out  SW=$clog2(3*WIDTH+1)  raw accumulated sum.

Behaviour:
- Reset values:
  - state IDLE.
  - grant=0, busy=0, res_valid=0, res_class=0, res_id=0, res_sum=0.
  - accumulator 0, bit index 0.
  - round-robin pointer last=N-1, so requester 0 wins first.
  - weights restored to default: entries 0,4,12,20,24 = 2'b10; entries 2,10,14,22 = 2'b01; all others 2'b00.
- FSM states: IDLE → RUN → RESULT → IDLE.
- IDLE:
  - If req≠0, grant is asserted combinationally for the first set req bit searching last+1, last+2, … mod N.
  - At that edge: req_data slice captured into the pattern register, last ← winner, id register ← winner, accumulator ← 0, index ← 0, state → RUN.
  - grant is 0 in every state other than IDLE.
  - A requester must hold req and its data stable until it sees its grant. req may drop without a grant; nothing is captured in that case.
- RUN, exactly WIDTH cycles:
  - Each cycle: acc ← acc + (weight[idx] & {2{pattern[idx]}}), zero-extended to SW bits; idx ← idx+1.
  - When idx==WIDTH-1 the final add occurs and state → RESULT.
  - No overflow is possible: the maximum sum is 3*WIDTH.
- RESULT, one cycle:
  - res_valid=1.
  - res_sum=acc.
  - res_class = 2'b10 if acc==MATCH_A; else 2'b01 if acc==MATCH_B; else 2'b00.
  - res_id = latched winner.
  - State → IDLE.
- res_class, res_sum and res_id are registered and hold their values until the next RESULT.
- Timing:
  - With grant in cycle T, res_valid occurs in cycle T+WIDTH+1.
  - The earliest next grant is in cycle T+WIDTH+2.
  - Back-to-back jobs therefore have a period of WIDTH+2.
- Weight writes:
  - Applied at the edge only when cfg_we=1, state==IDLE and cfg_addr<WIDTH.
  - Otherwise the write is silently dropped: in RUN/RESULT or when the address is out of range.
  - A write and a grant in the same IDLE cycle both take effect; the granted job uses the new weight.
- Reset:
  - rst wins over every other input, including mid-RUN.
  - The in-flight job is discarded: no res_valid, and its grant is not reissued.
  - Weights return to default.
- N=1: the arbiter degenerates and res_id is always 0.

Test Plan:
- Reset; req=4'b0001, data0 bits {0,4,12,20,24} set → grant=0001 at cycle T; res_valid at T+26 with res_sum=10, res_class=2'b10, res_id=0; busy high T+1..T+26.
- req=4'b0100, data2 bits {2,10,14,22} set → res_sum=4, res_class=2'b01, res_id=2. Then data all ones → res_sum=14, res_class=2'b00.
- req=4'b1111 held, distinct patterns → grants in order 0001, 0010, 0100, 1000, 0001, spaced 27 cycles apart; res_id sequence 0,1,2,3,0.
- In IDLE write cfg_addr=1, cfg_wdata=3; pattern with only bit 1 set → res_sum=3. During RUN write addr 0 data 0; next job with bit 0 only → res_sum=2 (write ignored). Write with addr 25 → no effect.
- Same-cycle cfg write (addr 2, data 3) and grant with pattern bit 2 only → res_sum=3.
- rst asserted in the 10th RUN cycle → res_valid stays 0, busy=0 next cycle; a following job with the default-pattern data → sum 10, class 2'b10, requester 0 wins first.
